// File: rtl/vga_sync_rx.sv
// -----------------------------------------------------------------------------
// vga_sync_rx
// Recovers raster timing from free-running HS/VS inputs. It measures the line
// length (clocks) and frame length (lines), and declares lock once
// LOCK_FRAMES consecutive frames repeat the same geometry. While locked it
// produces hcount/vcount/de, and it drops lock with a one-clock err pulse when
// the timing breaks.
//
// Optional build macro:
//   VGA_SYNC_RX_POLARITY_DETECT_EN - per-signal sync polarity detection. A
//   sync is taken as active-high when it spends more clocks low than high over
//   the last complete line (HS) or frame (VS). A polarity change forces SEARCH.
//   When the macro is undefined, both syncs are active-high.
//
// Ports:
//   clk       in   pixel clock
//   arstn     in   asynchronous active-low reset
//   hs_in     in   horizontal sync, asynchronous to clk
//   vs_in     in   vertical sync, asynchronous to clk
//   hcount    out  [11:0] horizontal position, 0 = first sync clock
//   vcount    out  [11:0] line number, 0 = first vsync line
//   de        out  active-video strobe (locked only)
//   locked    out  timing stable
//   h_period  out  [11:0] last measured line length, clocks
//   v_lines   out  [11:0] last measured frame length, lines
//   err       out  one-clock pulse when timing breaks while locked
// -----------------------------------------------------------------------------
module vga_sync_rx #(
  parameter int HD          = 1280,
  parameter int HR          = 112,
  parameter int HB          = 248,
  parameter int VD          = 1024,
  parameter int VR          = 3,
  parameter int VB          = 38,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        de,
  output logic        locked,
  output logic [11:0] h_period,
  output logic [11:0] v_lines,
  output logic        err
);

  // state   | meaning
  // SEARCH  | waiting for a VS start; hcount/vcount held at 0
  // MEASURE | comparing each frame's geometry with the previous frame's
  // LOCKED  | geometry trusted; every line and frame is checked against it
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);
  localparam logic [11:0] DE_H0   = 12'(HR + HB);
  localparam logic [11:0] DE_H1   = 12'(HR + HB + HD);
  localparam logic [11:0] DE_V0   = 12'(VR + VB);
  localparam logic [11:0] DE_V1   = 12'(VR + VB + VD);

  // [0],[1] form the synchronizer; [2] is the previous synchronized value
  logic [2:0] hs_sync_q, vs_sync_q;
  logic       hs_s, hs_p, vs_s, vs_p;
  logic       hs_start, vs_start, pol_chg;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      hs_sync_q <= '0;
      vs_sync_q <= '0;
    end else begin
      hs_sync_q <= {hs_sync_q[1:0], hs_in};
      vs_sync_q <= {vs_sync_q[1:0], vs_in};
    end
  end

  assign hs_s = hs_sync_q[1];
  assign hs_p = hs_sync_q[2];
  assign vs_s = vs_sync_q[1];
  assign vs_p = vs_sync_q[2];

`ifdef VGA_SYNC_RX_POLARITY_DETECT_EN
  // High/low occupancy is counted between rising edges of the synchronized
  // signal. The choice of edge does not matter, because both edges repeat
  // once per line or frame.
  logic        hs_rise, vs_rise;
  logic        hs_pol_q, vs_pol_q;
  logic        hs_pol_new, vs_pol_new;
  logic [11:0] hs_hi_q, hs_lo_q;
  logic [21:0] vs_hi_q, vs_lo_q;

  assign hs_rise    = hs_s & ~hs_p;
  assign vs_rise    = vs_s & ~vs_p;
  assign hs_pol_new = (hs_lo_q > hs_hi_q);
  assign vs_pol_new = (vs_lo_q > vs_hi_q);
  assign pol_chg    = (hs_rise & (hs_pol_new != hs_pol_q)) |
                      (vs_rise & (vs_pol_new != vs_pol_q));
  assign hs_start   = hs_pol_q ? (hs_s & ~hs_p) : (~hs_s & hs_p);
  assign vs_start   = vs_pol_q ? (vs_s & ~vs_p) : (~vs_s & vs_p);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      hs_pol_q <= 1'b1;
      vs_pol_q <= 1'b1;
      hs_hi_q  <= '0;
      hs_lo_q  <= '0;
      vs_hi_q  <= '0;
      vs_lo_q  <= '0;
    end else begin
      if (hs_rise) begin
        hs_pol_q <= hs_pol_new;
        hs_hi_q  <= 12'd1;
        hs_lo_q  <= '0;
      end else if (hs_s) begin
        if (hs_hi_q != '1) hs_hi_q <= hs_hi_q + 12'd1;
      end else begin
        if (hs_lo_q != '1) hs_lo_q <= hs_lo_q + 12'd1;
      end
      if (vs_rise) begin
        vs_pol_q <= vs_pol_new;
        vs_hi_q  <= 22'd1;
        vs_lo_q  <= '0;
      end else if (vs_s) begin
        if (vs_hi_q != '1) vs_hi_q <= vs_hi_q + 22'd1;
      end else begin
        if (vs_lo_q != '1) vs_lo_q <= vs_lo_q + 22'd1;
      end
    end
  end
`else
  assign hs_start = hs_s & ~hs_p;
  assign vs_start = vs_s & ~vs_p;
  assign pol_chg  = 1'b0;
`endif

  logic [11:0] hcnt_q, vcnt_q, h_period_q, v_lines_q;
  logic [11:0] h_meas, v_meas;
  logic        vs_pend_q, frame_end;

  assign h_meas    = hcnt_q + 12'd1;
  assign v_meas    = vcnt_q + 12'd1;
  // A frame closes on the first HS start at or after a VS start, including
  // the case where both starts fall on the same clock.
  assign frame_end = hs_start & (vs_start | vs_pend_q);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      vs_pend_q  <= 1'b0;
      h_period_q <= '0;
      v_lines_q  <= '0;
    end else begin
      if (hs_start) begin
        hcnt_q     <= '0;
        h_period_q <= h_meas;
      end else if (hcnt_q != CNT_MAX) begin
        hcnt_q <= h_meas;
      end
      if (frame_end) begin
        vcnt_q    <= '0;
        v_lines_q <= v_meas;
      end else if (hs_start && vcnt_q != CNT_MAX) begin
        vcnt_q <= v_meas;
      end
      if (hs_start)      vs_pend_q <= 1'b0;
      else if (vs_start) vs_pend_q <= 1'b1;
    end
  end

  state_t      state_q;
  logic [3:0]  match_q;
  logic [11:0] prev_h_q, prev_v_q;
  logic        prev_vld_q, err_q, lock_fault;

  // A frame that runs past v_lines is caught on the extra line, so a missing
  // VS does not leave a stale lock in place until the line counter saturates.
  assign lock_fault = (hs_start && h_meas != h_period_q) ||
                      (frame_end && v_meas != v_lines_q) ||
                      (hs_start && !frame_end && v_meas >= v_lines_q) ||
                      (hcnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= SEARCH;
      match_q    <= '0;
      prev_h_q   <= '0;
      prev_v_q   <= '0;
      prev_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (pol_chg) begin
        state_q    <= SEARCH;
        match_q    <= '0;
        prev_vld_q <= 1'b0;
      end else begin
        case (state_q)
          SEARCH: begin
            prev_vld_q <= 1'b0;
            if (vs_start) begin
              state_q <= MEASURE;
              match_q <= '0;
              if (frame_end) begin
                prev_h_q   <= h_meas;
                prev_v_q   <= v_meas;
                prev_vld_q <= 1'b1;
              end
            end
          end
          MEASURE: begin
            if (frame_end) begin
              if (prev_vld_q && h_meas == prev_h_q && v_meas == prev_v_q) begin
                if (match_q + 4'd1 >= LOCK_N) state_q <= LOCKED;
                match_q <= match_q + 4'd1;
              end else begin
                match_q <= '0;
              end
              prev_h_q   <= h_meas;
              prev_v_q   <= v_meas;
              prev_vld_q <= 1'b1;
            end
          end
          LOCKED: begin
            if (lock_fault) begin
              state_q    <= SEARCH;
              match_q    <= '0;
              prev_vld_q <= 1'b0;
              err_q      <= 1'b1;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign locked   = (state_q == LOCKED);
  assign hcount   = (state_q == SEARCH) ? '0 : hcnt_q;
  assign vcount   = (state_q == SEARCH) ? '0 : vcnt_q;
  assign h_period = h_period_q;
  assign v_lines  = v_lines_q;
  assign err      = err_q;
  assign de       = locked &&
                    (hcnt_q >= DE_H0) && (hcnt_q < DE_H1) &&
                    (vcnt_q >= DE_V0) && (vcnt_q < DE_V1);

endmodule

// File: tb/tb_vga_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_rx
// Directed bench for vga_sync_rx using a reduced raster: 30 clocks per line
// (sync 4, back porch 6, active 16, front porch 4) and 15 lines per frame
// (sync 2, back porch 3, active 8, front porch 2).
// The pins are driven on the falling clock edge. DUT outputs are sampled on
// the same falling edge, before the pins change.
// -----------------------------------------------------------------------------
module tb_vga_sync_rx;

  localparam int HD = 16, HR = 4, HB = 6, HF = 4;
  localparam int VD = 8,  VR = 2, VB = 3, VF = 2;
  localparam int HT = HR + HB + HD + HF;
  localparam int VT = VR + VB + VD + VF;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic [11:0] hcount, vcount, h_period, v_lines;
  logic        de, locked, err;

  vga_sync_rx #(
    .HD(HD), .HR(HR), .HB(HB), .VD(VD), .VR(VR), .VB(VB), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .arstn(arstn), .hs_in(hs_in), .vs_in(vs_in),
    .hcount(hcount), .vcount(vcount), .de(de), .locked(locked),
    .h_period(h_period), .v_lines(v_lines), .err(err)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0;
  int   gen_h = 0, gen_v = 0, cyc = 0;
  logic gen_en = 1'b0, inv = 1'b0, short_line = 1'b0;
  int   err_cyc = 0, de_frame = 0, de_lines = 0, de_run = 0, last_run = 0;
  int   hs_edge_cyc = 0, de_delay = 0;
  logic de_prev = 1'b0, rise_pending = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr_mon();
    err_cyc = 0; de_frame = 0; de_lines = 0; de_run = 0; last_run = 0;
    de_delay = 0; rise_pending = 1'b0;
  endtask

  // One pixel clock: sample outputs, then drive the next pin values.
  task automatic step();
    int line_len;
    @(negedge clk);
    if (err) err_cyc++;
    if (de) begin
      de_frame++;
      de_run++;
      if (!de_prev) begin
        de_lines++;
        if (rise_pending) begin
          de_delay = cyc - hs_edge_cyc;
          rise_pending = 1'b0;
        end
      end
    end else if (de_prev) begin
      last_run = de_run;
      de_run = 0;
    end
    de_prev = de;
    if (!gen_en) begin
      hs_in = inv;
      vs_in = inv;
    end else begin
      hs_in = (gen_h < HR) ^ inv;
      vs_in = (gen_v < VR) ^ inv;
      if (gen_h == 0 && gen_v == VR + VB) begin
        hs_edge_cyc = cyc;
        rise_pending = 1'b1;
      end
      line_len = (short_line && gen_v == 7) ? HT - 1 : HT;
      if (gen_h == line_len - 1) begin
        gen_h = 0;
        if (gen_v == 7) short_line = 1'b0;
        gen_v = (gen_v == VT - 1) ? 0 : gen_v + 1;
      end else begin
        gen_h++;
      end
    end
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Run through n frame-start pin edges, then 4 more clocks so the DUT has
  // acted on the last one (hcount reads 1 on return).
  task automatic to_frame_start(input int n);
    int seen;
    int guard;
    seen = 0;
    guard = 0;
    while (seen < n && guard < 20000) begin
      if (gen_en && gen_h == 0 && gen_v == 0) seen++;
      step();
      guard++;
    end
    chk("frame_start_reached", seen, n);
    steps(4);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hcount"}, hcount, 0);
    chk({tag, "_vcount"}, vcount, 0);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_h_period"}, h_period, 0);
    chk({tag, "_v_lines"}, v_lines, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    steps(3);
    #1;
    chk_all_zero("reset");
    steps(2);
    arstn = 1'b1;
    gen_en = 1'b1;

    // initial lock: the first VS enters MEASURE, and lock follows the third frame end
    to_frame_start(3);
    chk("lock_after_e3", locked, 0);
    to_frame_start(1);
    chk("lock_after_e4", locked, 1);
    chk("h_period", h_period, HT);
    chk("v_lines", v_lines, VT);
    chk("hcount_frame_start", hcount, 1);
    chk("vcount_frame_start", vcount, 0);

    // one full locked frame of de
    clr_mon();
    to_frame_start(1);
    chk("de_clocks_per_frame", de_frame, HD * VD);
    chk("de_lines_per_frame", de_lines, VD);
    chk("de_clocks_per_line", last_run, HD);
    chk("de_delay_from_pin", de_delay, 3 + HR + HB);
    chk("err_quiet_locked", err_cyc, 0);

    // de horizontal boundaries on the first active line
    steps(150);
    chk("hcount_line5", hcount, 1);
    chk("vcount_line5", vcount, VR + VB);
    steps(8);
    chk("de_hcount9", de, 0);
    steps(1);
    chk("de_hcount10", de, 1);
    steps(15);
    chk("de_hcount25", de, 1);
    steps(1);
    chk("de_hcount26", de, 0);

    // one 29-clock line drops lock, and two good frames relock
    clr_mon();
    short_line = 1'b1;
    to_frame_start(1);
    chk("short_err_cycles", err_cyc, 1);
    chk("short_unlocked", locked, 0);
    to_frame_start(1);
    chk("short_relock_e2", locked, 0);
    to_frame_start(1);
    chk("short_relock_e3", locked, 1);
    chk("short_err_once", err_cyc, 1);

    // HS/VS idle long enough to saturate the line counter
    clr_mon();
    gen_en = 1'b0;
    steps(5000);
    chk("sat_err_cycles", err_cyc, 1);
    chk("sat_unlocked", locked, 0);
    chk("sat_hcount", hcount, 0);
    chk("sat_vcount", vcount, 0);
    gen_h = 0;
    gen_v = 0;
    gen_en = 1'b1;
    to_frame_start(4);
    chk("sat_relock", locked, 1);
    chk("sat_relock_h_period", h_period, HT);

    // reset mid-frame while locked
    steps(180);
    arstn = 1'b0;
    #1;
    chk_all_zero("midreset");
    steps(3);
    arstn = 1'b1;
    to_frame_start(3);
    chk("rst_relock_e3", locked, 0);
    to_frame_start(1);
    chk("rst_relock_e4", locked, 1);
    chk("rst_relock_v_lines", v_lines, VT);

`ifdef VGA_SYNC_RX_POLARITY_DETECT_EN
    // active-low syncs
    arstn = 1'b0;
    gen_en = 1'b0;
    inv = 1'b1;
    steps(3);
    arstn = 1'b1;
    steps(100);
    gen_h = 0;
    gen_v = 0;
    gen_en = 1'b1;
    to_frame_start(5);
    chk("inv_locked", locked, 1);
    chk("inv_h_period", h_period, HT);
    chk("inv_v_lines", v_lines, VT);
    clr_mon();
    to_frame_start(1);
    chk("inv_de_delay", de_delay, 3 + HR + HB);
    chk("inv_de_clocks", de_frame, HD * VD);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter HD, default 1280: active pixels per line.
REQ-002 Parameter HR, default 112: expected hsync width, clocks.
REQ-003 Parameter HB, default 248: back porch, clocks.
REQ-004 Parameter VD, default 1024: active lines per frame.
REQ-005 Parameter VR, default 3: expected vsync width, lines.
REQ-006 Parameter VB, default 38: back porch, lines.
REQ-007 Parameter LOCK_FRAMES, default 2, range 1..15: consecutive matching frames required for lock.
REQ-008 clk  input  1: pixel clock.
REQ-009 arstn  input  1: reset, asynchronous, active-low.
REQ-010 hs_in  input  1: incoming horizontal sync, asynchronous to clk.
REQ-011 vs_in  input  1: incoming vertical sync, asynchronous to clk.
REQ-012 hcount  output  12: recovered horizontal position; 0 = first sync clock.
REQ-013 vcount  output  12: recovered line number; 0 = first vsync line.
REQ-014 de  output  1: active-video strobe.
REQ-015 locked  output  1: timing stable.
REQ-016 h_period  output  12: last measured line length in clocks.
REQ-017 v_lines  output  12: last measured frame length in lines.
REQ-018 err  output  1: one-cycle pulse on a measurement mismatch or overflow while locked.

Function
REQ-019 hs_in and vs_in SHALL each pass through a 2-FF synchronizer; an edge is detected on the synchronized signal, giving a 3-clk pin-to-event latency.
REQ-020 An HS start SHALL be the synchronized sync-asserting edge (rising for active-high); the same rule applies to VS.
REQ-021 The line counter SHALL load 0 on the cycle after an HS start and increment by 1 on all other cycles.
REQ-022 The line counter SHALL saturate at 4095.
REQ-023 On each HS start, h_period SHALL capture the line counter value + 1.
REQ-024 The line count SHALL increment on each HS start and load 0 on the first HS start at or after a VS start.
REQ-025 On that HS start, v_lines SHALL capture the previous line count + 1.
REQ-026 The FSM SHALL have states SEARCH, MEASURE and LOCKED.
REQ-027 SEARCH → MEASURE SHALL occur on the first VS start.
REQ-028 In MEASURE, at each frame end, the match counter SHALL increment if h_period and v_lines equal the prior frame's values, and reset to 0 otherwise.
REQ-029 MEASURE → LOCKED SHALL occur when the match counter reaches LOCK_FRAMES.
REQ-030 LOCKED → SEARCH SHALL occur, with err pulsed for 1 clk, on any of:
- a line length differing from h_period;
- a frame line count differing from v_lines;
- line counter saturation (no HS for 4096 clks).
REQ-031 hcount SHALL equal the line counter and vcount SHALL equal the line count; both hold 0 in SEARCH.
REQ-032 de SHALL be 1 only in LOCKED, with HR+HB <= hcount < HR+HB+HD and VR+VB <= vcount < VR+VB+VD; otherwise 0.
REQ-033 If HS and VS starts occur on the same clock, the line count SHALL load 0 on that clock.
REQ-034 A measured sync width differing from HR (clocks) or VR (lines) SHALL NOT affect lock; it is informational only.

Reset
REQ-035 While arstn = 0, all outputs SHALL be 0, the FSM SHALL be in SEARCH, and synchronizers, counters and match counter SHALL be cleared.
REQ-036 Reset asserted mid-frame SHALL take effect immediately; after release, lock SHALL require a fresh VS plus LOCK_FRAMES matching frames.

Configuration
REQ-037 With VGA_SYNC_RX_POLARITY_DETECT_EN defined, polarity SHALL be detected per signal: sync is active-high if the signal is low for more clks of the last complete line (HS) or frame (VS) than it is high, else active-low.
REQ-038 With the macro defined, a polarity change SHALL force SEARCH.
REQ-039 Without VGA_SYNC_RX_POLARITY_DETECT_EN, both syncs SHALL be treated as active-high and no polarity logic SHALL be present.

Verification
REQ-040 Default 1688x1066 timing, active-high syncs, 3 frames -> locked = 1 after frame 3 ends; h_period = 1688; v_lines = 1066.
REQ-041 While locked -> de rises 3 clk + (HR+HB) after the HS pin edge on line 41; exactly 1280 de clocks per active line; 1024 active lines per frame.
REQ-042 Locked; one line shortened to 1687 clks -> err pulses for 1 clk; locked = 0; relock after 2 good frames.
REQ-043 HS held idle for 5000 clks -> saturation at 4095; err pulse; SEARCH; hcount = vcount = 0.
REQ-044 arstn pulsed mid-frame while locked -> all outputs 0 during reset; locked = 0 until 2 full frames after the next VS.
REQ-045 With the macro defined, inverted (active-low) syncs -> lock achieved with identical h_period, v_lines and de alignment.
